// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the audio receive path.
//   rx_state_t   : receiver state (SYNC = hunting for a word boundary,
//                  RUN = capturing words)
//   BIT_CNT_W    : width of the per-word bit counter
//   BIT_CNT_MAX  : saturation value of the bit counter
//   sat_inc()    : saturating increment for the bit counter
// -----------------------------------------------------------------------------
package audio_pkg;

   localparam int BIT_CNT_W = 6;
   localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = '1;

   typedef enum logic {
      SYNC = 1'b0,
      RUN  = 1'b1
   } rx_state_t;

   // Counting stops at all-ones so an over-long word cannot wrap back into
   // looking like a short one.
   function automatic logic [BIT_CNT_W-1:0] sat_inc(input logic [BIT_CNT_W-1:0] v);
      if (v == BIT_CNT_MAX) begin
         return v;
      end
      return v + 1'b1;
   endfunction

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer bringing one asynchronous input into clk_sys.
//   clk_sys : destination clock
//   reset_n : asynchronous active-low reset, both flops clear to 0
//   d       : asynchronous input
//   q       : synchronized output, two clk_sys cycles behind d
// -----------------------------------------------------------------------------
module sync2 (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/i2s_rx.sv
// -----------------------------------------------------------------------------
// i2s_rx
// Standard I2S (one-bit-delayed, MSB-first) receiver. The external bit clock,
// word select and data are oversampled by clk_sys (at least 4x bck), rising
// bck edges become single-cycle bit events, and complete left/right words are
// presented as a coherent pair.
//
// Ports
//   clk_sys      : system clock, all logic lives here
//   reset_n      : asynchronous active-low reset
//   enable       : receiver enable; low drops back to SYNC within one clock
//   i2s_bck      : external bit clock (asynchronous)
//   i2s_lrck     : external word select, 0 = left, 1 = right (asynchronous)
//   i2s_data     : external serial data (asynchronous)
//   left         : last complete left sample (AUDIO_DW bits, two's complement)
//   right        : last complete right sample
//   sample_valid : one-cycle pulse when left/right update together
//   sync_err     : sticky, set when a word shorter than AUDIO_DW was received;
//                  cleared only by reset
// -----------------------------------------------------------------------------
module i2s_rx
   import audio_pkg::*;
#(
   parameter int AUDIO_DW = 16
) (
   input  logic                clk_sys,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                i2s_bck,
   input  logic                i2s_lrck,
   input  logic                i2s_data,
   output logic [AUDIO_DW-1:0] left,
   output logic [AUDIO_DW-1:0] right,
   output logic                sample_valid,
   output logic                sync_err
);

   localparam logic [BIT_CNT_W-1:0] DW_CNT  = BIT_CNT_W'(AUDIO_DW);
   localparam logic [AUDIO_DW-1:0]  MSB_ONE = {1'b1, {(AUDIO_DW-1){1'b0}}};

   // ---------------------------------------------------------------------
   // Input synchronization and bit-event detection
   // ---------------------------------------------------------------------
   logic bck_s;
   logic lrck_s;
   logic data_s;

   sync2 u_sync_bck (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .d       (i2s_bck),
      .q       (bck_s)
   );

   sync2 u_sync_lrck (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .d       (i2s_lrck),
      .q       (lrck_s)
   );

   sync2 u_sync_data (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .d       (i2s_data),
      .q       (data_s)
   );

   logic bck_d;
   logic lrck_prev;
   logic primed;
   logic bit_event;
   logic boundary;

   // All three inputs travel identical pipelines, so lrck_s and data_s in the
   // bit-event cycle are the values present when bck was first seen high.
   assign bit_event = bck_s & ~bck_d;

   // lrck_prev is meaningless until one bit event has been seen; without the
   // primed qualifier a reset released mid-right-word would fake a boundary
   // against the reset value of lrck_prev.
   assign boundary  = bit_event & primed & (lrck_s != lrck_prev);

   // ---------------------------------------------------------------------
   // Capture state
   // ---------------------------------------------------------------------
   rx_state_t              state;
   rx_state_t              state_next;
   logic [AUDIO_DW-1:0]    shift_reg;
   logic [AUDIO_DW-1:0]    shift_next;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic [BIT_CNT_W-1:0]   cnt_next;
   logic [BIT_CNT_W-1:0]   cnt_inc;
   logic [AUDIO_DW-1:0]    hold_left;
   logic [AUDIO_DW-1:0]    hold_next;
   logic                   hold_valid;
   logic                   hold_valid_next;
   logic [AUDIO_DW-1:0]    left_next;
   logic [AUDIO_DW-1:0]    right_next;
   logic                   valid_next;
   logic                   err_next;
   logic [AUDIO_DW-1:0]    word_cur;

   // Bits fill the register MSB first at position (AUDIO_DW-1-bit_cnt).
   // Once bit_cnt reaches AUDIO_DW the mask shifts out to zero, which drops
   // the surplus LSBs of long words. Because the register is cleared at
   // every boundary, short words come out left-aligned and zero-padded.
   assign word_cur = data_s ? (shift_reg | (MSB_ONE >> bit_cnt)) : shift_reg;
   assign cnt_inc  = sat_inc(bit_cnt);

   always_comb begin
      state_next      = state;
      shift_next      = shift_reg;
      cnt_next        = bit_cnt;
      hold_next       = hold_left;
      hold_valid_next = hold_valid;
      left_next       = left;
      right_next      = right;
      valid_next      = 1'b0;
      err_next        = sync_err;

      case (state)
         SYNC: begin
            // Partial word in flight is discarded; the first boundary only
            // establishes word alignment.
            shift_next      = '0;
            cnt_next        = '0;
            hold_valid_next = 1'b0;
            if (boundary) begin
               state_next = RUN;
            end
         end

         RUN: begin
            if (boundary) begin
               // The boundary bit is the last bit of the word for lrck_prev.
               shift_next = '0;
               cnt_next   = '0;
               if (cnt_inc < DW_CNT) begin
                  err_next = 1'b1;
               end
               if (!lrck_prev) begin
                  hold_next       = word_cur;
                  hold_valid_next = 1'b1;
               end else if (hold_valid) begin
                  left_next       = hold_left;
                  right_next      = word_cur;
                  valid_next      = 1'b1;
                  hold_valid_next = 1'b0;
               end
            end else if (bit_event) begin
               shift_next = word_cur;
               cnt_next   = cnt_inc;
            end
         end

         default: begin
            state_next = SYNC;
         end
      endcase

      // Disable wins over everything in the same cycle, so no word that was
      // partly received while disabled can ever reach the outputs.
      if (!enable) begin
         state_next      = SYNC;
         shift_next      = '0;
         cnt_next        = '0;
         hold_next       = hold_left;
         hold_valid_next = 1'b0;
         left_next       = left;
         right_next      = right;
         valid_next      = 1'b0;
         err_next        = sync_err;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state        <= SYNC;
         bck_d        <= 1'b0;
         lrck_prev    <= 1'b0;
         primed       <= 1'b0;
         shift_reg    <= '0;
         bit_cnt      <= '0;
         hold_left    <= '0;
         hold_valid   <= 1'b0;
         left         <= '0;
         right        <= '0;
         sample_valid <= 1'b0;
         sync_err     <= 1'b0;
      end else begin
         bck_d <= bck_s;
         if (bit_event) begin
            lrck_prev <= lrck_s;
            primed    <= 1'b1;
         end
         state        <= state_next;
         shift_reg    <= shift_next;
         bit_cnt      <= cnt_next;
         hold_left    <= hold_next;
         hold_valid   <= hold_valid_next;
         left         <= left_next;
         right        <= right_next;
         sample_valid <= valid_next;
         sync_err     <= err_next;
      end
   end

endmodule
